// File: rtl/sign_extend.sv
// Registered immediate extender: widens an IN_W-bit field to OUT_W bits (sign or zero fill), optional left shift.
// Build with SIGN_EXT_FLAGS_EN defined to add the registered ext_neg / ext_zero flag outputs.
module sign_extend #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 16,
    parameter bit ZERO_EXT = 1'b0,
    parameter int SHIFT    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  ext_in,
`ifdef SIGN_EXT_FLAGS_EN
    output logic             ext_neg,
    output logic             ext_zero,
`endif
    output logic [OUT_W-1:0] extend_out
);

    // Reject nonsensical widths/shifts at elaboration rather than silently truncating.
    generate
        if (IN_W < 1 || IN_W > OUT_W) begin : g_bad_in_w
            $error("sign_extend: IN_W=%0d must be in 1..OUT_W=%0d", IN_W, OUT_W);
        end
        if (SHIFT < 0 || SHIFT >= OUT_W) begin : g_bad_shift
            $error("sign_extend: SHIFT=%0d must be in 0..OUT_W-1=%0d", SHIFT, OUT_W - 1);
        end
    endgenerate

    logic             fill_bit;
    logic [OUT_W-1:0] ext_val;
    logic [OUT_W-1:0] extend_d;
    logic [OUT_W-1:0] extend_q;

    assign fill_bit = ZERO_EXT ? 1'b0 : ext_in[IN_W-1];

    // Bit-wise construction keeps IN_W == OUT_W legal (no empty part-selects).
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_ext
            if (gi < IN_W) begin : g_low
                assign ext_val[gi] = ext_in[gi];
            end else begin : g_fill
                assign ext_val[gi] = fill_bit;
            end
        end

        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_shift
            if (gi >= SHIFT) begin : g_keep
                assign extend_d[gi] = ext_val[gi-SHIFT];
            end else begin : g_zero
                assign extend_d[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            extend_q <= '0;
        end else begin
            extend_q <= extend_d;
        end
    end

    assign extend_out = extend_q;

`ifdef SIGN_EXT_FLAGS_EN
    logic neg_q;
    logic zero_q;

    // Flags are derived from the next value so they line up with extend_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            neg_q  <= extend_d[OUT_W-1];
            zero_q <= ~|extend_d;
        end
    end

    assign ext_neg  = neg_q;
    assign ext_zero = zero_q;
`endif

endmodule

// File: tb/tb_sign_extend.sv
// Randomised and directed checks of sign_extend (default, zero-extend and shift-by-1 builds) against an arithmetic model.
module tb_sign_extend;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ext_in;
    logic [15:0] out_def;
    logic [15:0] out_zx;
    logic [15:0] out_sh;
    int          total;
    int          bad;

`ifdef SIGN_EXT_FLAGS_EN
    logic neg_def, zero_def, neg_zx, zero_zx, neg_sh, zero_sh;
`endif

    sign_extend #(.IN_W(8), .OUT_W(16), .ZERO_EXT(1'b0), .SHIFT(0)) u_def (
        .clk(clk), .rst_n(rst_n), .ext_in(ext_in),
`ifdef SIGN_EXT_FLAGS_EN
        .ext_neg(neg_def), .ext_zero(zero_def),
`endif
        .extend_out(out_def)
    );

    sign_extend #(.IN_W(8), .OUT_W(16), .ZERO_EXT(1'b1), .SHIFT(0)) u_zx (
        .clk(clk), .rst_n(rst_n), .ext_in(ext_in),
`ifdef SIGN_EXT_FLAGS_EN
        .ext_neg(neg_zx), .ext_zero(zero_zx),
`endif
        .extend_out(out_zx)
    );

    sign_extend #(.IN_W(8), .OUT_W(16), .ZERO_EXT(1'b0), .SHIFT(1)) u_sh (
        .clk(clk), .rst_n(rst_n), .ext_in(ext_in),
`ifdef SIGN_EXT_FLAGS_EN
        .ext_neg(neg_sh), .ext_zero(zero_sh),
`endif
        .extend_out(out_sh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: interpret the field as a signed/unsigned integer, scale by 2**sh, wrap to 16 bits.
    function automatic logic [15:0] ref_ext(input logic [7:0] v, input bit zext, input int sh);
        longint x;
        x = longint'(v);
        if (!zext && v >= 8'd128) x = x - 256;
        x = x * (longint'(1) << sh);
        return 16'(x);
    endfunction

    // Present a value after a falling edge, then let one rising edge capture it.
    task automatic step(input logic [7:0] v);
        @(negedge clk);
        ext_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ext_in = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (out_def !== 16'h0000 || out_zx !== 16'h0000 || out_sh !== 16'h0000) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got def=%h zx=%h sh=%h want 0000", i, out_def, out_zx, out_sh);
            end
`ifdef SIGN_EXT_FLAGS_EN
            total++;
            if ({neg_def, zero_def, neg_zx, zero_zx, neg_sh, zero_sh} !== 6'b0) begin
                bad++;
                $display("FAIL reset_flags cyc=%0d got %b want 000000", i,
                         {neg_def, zero_def, neg_zx, zero_zx, neg_sh, zero_sh});
            end
`endif
        end
        $display("reset hold: extend_out=%h", out_def);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_negative();
        step(8'h80);
        total++;
        if (out_def !== 16'hFF80) begin
            bad++;
            $display("FAIL negative got %h want FF80", out_def);
        end
        $display("neg: in=80 out=%h", out_def);
        step(8'h00);
        total++;
        if (out_def !== 16'h0000) begin
            bad++;
            $display("FAIL neg_then_zero got %h want 0000", out_def);
        end
        $display("neg: in=00 out=%h", out_def);
    endtask

    task automatic test_boundaries();
        logic [7:0]  vals [4];
        logic [15:0] want [4];
        vals = '{8'h00, 8'h7F, 8'h80, 8'hFF};
        want = '{16'h0000, 16'h007F, 16'hFF80, 16'hFFFF};
        for (int i = 0; i < 4; i++) begin
            step(vals[i]);
            total++;
            if (out_def !== want[i]) begin
                bad++;
                $display("FAIL boundary in=%h got %h want %h", vals[i], out_def, want[i]);
            end
`ifdef SIGN_EXT_FLAGS_EN
            total++;
            if (neg_def !== want[i][15] || zero_def !== (want[i] == 16'h0)) begin
                bad++;
                $display("FAIL boundary_flags in=%h got neg=%b zero=%b want neg=%b zero=%b",
                         vals[i], neg_def, zero_def, want[i][15], want[i] == 16'h0);
            end
`endif
            $display("boundary: in=%h out=%h", vals[i], out_def);
        end
    endtask

    task automatic test_params();
        step(8'h80);
        total++;
        if (out_zx !== 16'h0080) begin
            bad++;
            $display("FAIL zero_ext got %h want 0080", out_zx);
        end
        $display("zext: in=80 out=%h", out_zx);
        step(8'hC0);
        total++;
        if (out_sh !== 16'hFF80) begin
            bad++;
            $display("FAIL shift1 got %h want FF80", out_sh);
        end
        $display("shift1: in=C0 out=%h", out_sh);
    endtask

    task automatic test_latency();
        step(8'h12);
        @(negedge clk);
        ext_in = 8'hF3;
        #2;
        total++;
        if (out_def !== 16'h0012) begin
            bad++;
            $display("FAIL latency_hold got %h want 0012", out_def);
        end
        @(posedge clk);
        #1;
        total++;
        if (out_def !== 16'hFFF3) begin
            bad++;
            $display("FAIL latency_update got %h want FFF3", out_def);
        end
        $display("latency: held=0012 then out=%h", out_def);
    endtask

    task automatic test_random();
        logic [7:0] v;
        for (int i = 0; i < 200; i++) begin
            v = 8'($urandom_range(0, 255));
            step(v);
            total++;
            if (out_def !== ref_ext(v, 1'b0, 0) || out_zx !== ref_ext(v, 1'b1, 0) ||
                out_sh !== ref_ext(v, 1'b0, 1)) begin
                bad++;
                $display("FAIL random in=%h got def=%h zx=%h sh=%h want def=%h zx=%h sh=%h", v,
                         out_def, out_zx, out_sh, ref_ext(v, 1'b0, 0), ref_ext(v, 1'b1, 0),
                         ref_ext(v, 1'b0, 1));
            end
`ifdef SIGN_EXT_FLAGS_EN
            total++;
            if (neg_sh !== ref_ext(v, 1'b0, 1) >= 16'h8000 || zero_sh !== (ref_ext(v, 1'b0, 1) == 16'h0) ||
                neg_zx !== 1'b0 || zero_zx !== (v == 8'h0)) begin
                bad++;
                $display("FAIL random_flags in=%h got sh=%b%b zx=%b%b", v, neg_sh, zero_sh, neg_zx, zero_zx);
            end
`endif
            $display("random: in=%h def=%h zx=%h sh=%h", v, out_def, out_zx, out_sh);
        end
    endtask

    task automatic test_async_reset();
        step(8'hFF);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_def !== 16'h0000 || out_zx !== 16'h0000 || out_sh !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset got def=%h zx=%h sh=%h want 0000", out_def, out_zx, out_sh);
        end
        $display("async reset: out=%h", out_def);
        @(negedge clk);
        rst_n  = 1'b1;
        ext_in = 8'h81;
        @(posedge clk);
        #1;
        total++;
        if (out_def !== 16'hFF81) begin
            bad++;
            $display("FAIL reset_release got %h want FF81", out_def);
        end
        $display("release: in=81 out=%h", out_def);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        ext_in = 8'h00;
        test_reset();
        test_negative();
        test_boundaries();
        test_params();
        test_latency();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
